// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller behind the EX/MEM register.
// Runs a request/acknowledge transaction for loads and stores. Stalls the
// pipeline while the access is outstanding. Registers the write-back result
// toward MEM/WB, inserting bubbles while stalled.

module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] reg_data2_in,
    input  logic [63:0] bl_write_data_in,
    input  logic [4:0]  rd_in,
    input  logic [5:0]  control_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        mem_fault
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // The counter holds (BUSY cycles elapsed - 1), so the last allowed BUSY
    // cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] LP_LAST_CYCLE = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_count;
    logic [63:0] r_loadData;

    logic w_regWrite;
    logic w_memToReg;
    logic w_memRead;
    logic w_memWrite;
    logic w_bl;
    logic w_memOp;
    logic w_issue;
    logic w_ackTake;
    logic w_timeout;
    logic w_unusedFlagWrite;

    assign w_regWrite        = control_in[0];
    assign w_memToReg        = control_in[1];
    assign w_memRead         = control_in[2];
    assign w_memWrite        = control_in[3];
    assign w_bl              = control_in[4];
    assign w_unusedFlagWrite = control_in[5];
    assign w_memOp           = w_memRead | w_memWrite;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, stall, and single-cycle strobes for the datapath
    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        w_issue     = 1'b0;
        w_ackTake   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memOp) begin
                    stall       = 1'b1;
                    w_issue     = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    w_ackTake   = 1'b1;
                    w_nextState = DONE;
                end else if (r_count == LP_LAST_CYCLE) begin
                    w_timeout   = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Memory request registers, wait counter, captured load data and fault pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_fault  <= 1'b0;
            r_count    <= '0;
            r_loadData <= '0;
        end else begin
            mem_fault <= 1'b0;
            if (w_issue) begin
                mem_req   <= 1'b1;
                mem_we    <= w_memWrite;
                mem_addr  <= alu_result_in;
                mem_wdata <= reg_data2_in;
                r_count   <= '0;
            end else if (r_state == BUSY) begin
                r_count <= r_count + 8'd1;
                if (w_ackTake) begin
                    mem_req    <= 1'b0;
                    r_loadData <= mem_we ? 64'd0 : mem_rdata;
                end else if (w_timeout) begin
                    mem_req    <= 1'b0;
                    r_loadData <= '0;
                    mem_fault  <= 1'b1;
                end
            end
        end
    end

    // Write-back register: bubble while stalled, otherwise pass the selected result
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else if (stall) begin
            wb_reg_write <= 1'b0;
        end else begin
            wb_rd        <= rd_in;
            wb_reg_write <= w_regWrite;
            wb_data      <= w_bl       ? bl_write_data_in :
                            w_memToReg ? r_loadData       :
                                         alu_result_in;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven directed vectors, hand-written reset and
// stray-ack sequences, then random operations checked against a reference model.

module tb_mem_access_ctrl;

    localparam int TIMEOUT_P = 4;

    logic        clk;
    logic        reset;
    logic [63:0] alu_result_in;
    logic [63:0] reg_data2_in;
    logic [63:0] bl_write_data_in;
    logic [4:0]  rd_in;
    logic [5:0]  control_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;
    logic [63:0] modelLoad;

    typedef struct {
        logic [5:0]  ctrl;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] bl;
        logic [4:0]  rd;
        int          ackK;
        logic [63:0] rdata;
        int          expStall;
        int          expReq;
        int          expFault;
        logic        expWe;
        logic [63:0] expWbData;
        logic [4:0]  expWbRd;
        logic        expWbWe;
    } vec_t;

    vec_t vecs[10];

    mem_access_ctrl #(.TIMEOUT(TIMEOUT_P)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_result_in    (alu_result_in),
        .reg_data2_in     (reg_data2_in),
        .bl_write_data_in (bl_write_data_in),
        .rd_in            (rd_in),
        .control_in       (control_in),
        .stall            (stall),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .wb_data          (wb_data),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .mem_fault        (mem_fault)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [5:0] c, input logic [63:0] a, input logic [63:0] w,
                                   input logic [63:0] b, input logic [4:0] r, input int k,
                                   input logic [63:0] rdat, input int es, input int er, input int ef,
                                   input logic ewe, input logic [63:0] ewb, input logic [4:0] ewrd,
                                   input logic ewbwe);
        vec_t v;
        v.ctrl = c; v.alu = a; v.wdata = w; v.bl = b; v.rd = r; v.ackK = k; v.rdata = rdat;
        v.expStall = es; v.expReq = er; v.expFault = ef; v.expWe = ewe;
        v.expWbData = ewb; v.expWbRd = ewrd; v.expWbWe = ewbwe;
        return v;
    endfunction

    // Load data the controller holds after an operation completes
    function automatic logic [63:0] nextLoad(input vec_t v, input logic [63:0] prev);
        bit acked;
        acked = (v.ackK >= 1) && (v.ackK <= TIMEOUT_P);
        if (!(v.ctrl[2] | v.ctrl[3])) return prev;
        if (v.ctrl[3]) return 64'd0;
        if (acked) return v.rdata;
        return 64'd0;
    endfunction

    // Reference model: whole-transaction expectations from the operation rules
    function automatic vec_t refModel(input vec_t v, input logic [63:0] prevLoad);
        vec_t o;
        bit memOp;
        bit acked;
        logic [63:0] ld;
        o = v;
        memOp = v.ctrl[2] | v.ctrl[3];
        acked = (v.ackK >= 1) && (v.ackK <= TIMEOUT_P);
        o.expStall  = !memOp ? 0 : (acked ? v.ackK + 1 : TIMEOUT_P + 1);
        o.expReq    = !memOp ? 0 : (acked ? v.ackK : TIMEOUT_P);
        o.expFault  = (memOp && !acked) ? 1 : 0;
        o.expWe     = v.ctrl[3];
        ld          = nextLoad(v, prevLoad);
        o.expWbData = v.ctrl[4] ? v.bl : (v.ctrl[1] ? ld : v.alu);
        o.expWbRd   = v.rd;
        o.expWbWe   = v.ctrl[0];
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one EX/MEM operation, act as the memory, and check the whole transaction
    task automatic applyStimulus(input vec_t v);
        int  stallCount;
        int  reqCount;
        int  faultCount;
        int  cyc;
        bit  done;
        stallCount = 0; reqCount = 0; faultCount = 0; cyc = 0; done = 0;
        @(negedge clk);
        control_in       = v.ctrl;
        alu_result_in    = v.alu;
        reg_data2_in     = v.wdata;
        bl_write_data_in = v.bl;
        rd_in            = v.rd;
        mem_ack          = 1'b0;
        while (!done && cyc < TIMEOUT_P + 6) begin
            #1;
            if (mem_req) begin
                reqCount++;
                checkOutput("mem_addr", mem_addr, v.alu);
                checkOutput("mem_we", 64'(mem_we), 64'(v.expWe));
                if (v.expWe) checkOutput("mem_wdata", mem_wdata, v.wdata);
                checkOutput("wb_bubble", 64'(wb_reg_write), 64'd0);
                if (reqCount == v.ackK) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = {$urandom, $urandom};
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (mem_fault) faultCount++;
            if (stall) stallCount++;
            else done = 1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            cyc++;
            if (!done) @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL op_complete actual=stuck required=done ctrl=%b", v.ctrl);
        end else begin
            checkOutput("stall_cycles", 64'(stallCount), 64'(v.expStall));
            checkOutput("req_cycles", 64'(reqCount), 64'(v.expReq));
            checkOutput("fault_cycles", 64'(faultCount), 64'(v.expFault));
            checkOutput("wb_data", wb_data, v.expWbData);
            checkOutput("wb_rd", 64'(wb_rd), 64'(v.expWbRd));
            checkOutput("wb_reg_write", 64'(wb_reg_write), 64'(v.expWbWe));
        end
    endtask

    // Main sequence
    initial begin
        vec_t r;
        int   seen;
        int   cyc;

        vecs[0] = mkVec(6'b000001, 64'h10, 64'h0,    64'h0,    5'd3,  0, 64'h0,
                        0, 0, 0, 1'b0, 64'h10,        5'd3,  1'b1);
        vecs[1] = mkVec(6'b000111, 64'h40, 64'h0,    64'h0,    5'd5,  3, 64'hDEAD_BEEF,
                        4, 3, 0, 1'b0, 64'hDEAD_BEEF, 5'd5,  1'b1);
        vecs[2] = mkVec(6'b010001, 64'h7,  64'h0,    64'h1004, 5'd30, 0, 64'h0,
                        0, 0, 0, 1'b0, 64'h1004,      5'd30, 1'b1);
        vecs[3] = mkVec(6'b001000, 64'h80, 64'h1234, 64'h0,    5'd0,  1, 64'h0,
                        2, 1, 0, 1'b1, 64'h80,        5'd0,  1'b0);
        vecs[4] = mkVec(6'b000111, 64'h48, 64'h0,    64'h0,    5'd7,  0, 64'h0,
                        5, 4, 1, 1'b0, 64'h0,         5'd7,  1'b1);
        vecs[5] = mkVec(6'b000111, 64'h50, 64'h0,    64'h0,    5'd8,  4, 64'hCAFE,
                        5, 4, 0, 1'b0, 64'hCAFE,      5'd8,  1'b1);
        vecs[6] = mkVec(6'b000011, 64'h70, 64'h0,    64'h0,    5'd10, 0, 64'h0,
                        0, 0, 0, 1'b0, 64'hCAFE,      5'd10, 1'b1);
        vecs[7] = mkVec(6'b001111, 64'h60, 64'h55,   64'h0,    5'd9,  2, 64'h99,
                        3, 2, 0, 1'b1, 64'h0,         5'd9,  1'b1);
        vecs[8] = mkVec(6'b010101, 64'h90, 64'h0,    64'h2000, 5'd11, 2, 64'h77,
                        3, 2, 0, 1'b0, 64'h2000,      5'd11, 1'b1);
        vecs[9] = mkVec(6'b100000, 64'h5,  64'h0,    64'h0,    5'd12, 0, 64'h0,
                        0, 0, 0, 1'b0, 64'h5,         5'd12, 1'b0);

        reset = 1'b1;
        control_in = '0; alu_result_in = '0; reg_data2_in = '0; bl_write_data_in = '0;
        rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        modelLoad = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
        checkOutput("rst_wb_data", wb_data, 64'd0);
        checkOutput("rst_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        checkOutput("rst_mem_fault", 64'(mem_fault), 64'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            modelLoad = nextLoad(vecs[i], modelLoad);
        end

        // Stray ack while idle must not disturb captured load data or start anything
        @(negedge clk);
        control_in = 6'b000000;
        mem_ack    = 1'b1;
        mem_rdata  = 64'h1111_2222;
        #1;
        checkOutput("idle_ack_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        checkOutput("idle_ack_mem_req", 64'(mem_req), 64'd0);
        checkOutput("idle_ack_stall2", 64'(stall), 64'd0);
        r = mkVec(6'b000011, 64'h33, 64'h0, 64'h0, 5'd14, 0, 64'h0, 0, 0, 0, 1'b0, 64'h0, 5'd0, 1'b0);
        r = refModel(r, modelLoad);
        applyStimulus(r);
        modelLoad = nextLoad(r, modelLoad);

        // Reset on the 2nd BUSY cycle, then a stray ack after reset
        @(negedge clk);
        control_in    = 6'b000111;
        alu_result_in = 64'h200;
        rd_in         = 5'd4;
        seen = 0;
        cyc  = 0;
        while (seen < 2 && cyc < 20) begin
            #1;
            if (mem_req) seen++;
            if (seen < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("mid_rst_reached_busy2", 64'(seen), 64'd2);
        reset      = 1'b1;
        control_in = 6'b000000;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD0_BAD0;
        checkOutput("mid_rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("mid_rst_mem_addr", mem_addr, 64'd0);
        checkOutput("mid_rst_wb_reg_write", 64'(wb_reg_write), 64'd0);
        checkOutput("mid_rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        checkOutput("late_ack_mem_req", 64'(mem_req), 64'd0);
        checkOutput("late_ack_mem_fault", 64'(mem_fault), 64'd0);
        checkOutput("late_ack_stall", 64'(stall), 64'd0);
        modelLoad = '0;
        r = mkVec(6'b000011, 64'h44, 64'h0, 64'h0, 5'd15, 0, 64'h0, 0, 0, 0, 1'b0, 64'h0, 5'd0, 1'b0);
        r = refModel(r, modelLoad);
        applyStimulus(r);
        modelLoad = nextLoad(r, modelLoad);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            r.ctrl  = 6'($urandom);
            r.alu   = {$urandom, $urandom};
            r.wdata = {$urandom, $urandom};
            r.bl    = {$urandom, $urandom};
            r.rd    = 5'($urandom);
            r.ackK  = int'($urandom_range(0, TIMEOUT_P + 1));
            r.rdata = {$urandom, $urandom};
            r = refModel(r, modelLoad);
            applyStimulus(r);
            modelLoad = nextLoad(r, modelLoad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
